// File: rtl/bj_pkg.sv
`default_nettype none
// ============================================================================
//  Module : bj_pkg
//  Blackjack round-sequencer states, result codes, limits and card helpers.
//  Rev    : 1.0  initial release
// ============================================================================
package bj_pkg;

  typedef enum logic [3:0] {
    SHUFFLE,
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    WAIT,
    PLAYER_TURN,
    PLAYER_DRAW,
    DEALER_TURN,
    DEALER_DRAW,
    RESULT
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_TIE  = 2'b11;

  localparam logic [4:0] BJ_LIMIT     = 5'd21;
  localparam logic [4:0] DEALER_STAND = 5'd17;

  // Faces and illegal ranks both count as 10; aces count as 1 here.
  function automatic logic [4:0] card_value(input logic [3:0] rank);
    if (rank >= 4'd1 && rank <= 4'd10) return {1'b0, rank};
    return 5'd10;
  endfunction

  function automatic logic bad_rank(input logic [3:0] rank);
    return (rank == 4'd0) || (rank > 4'd13);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bj_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module : bj_round_ctrl_if
//  Shuffle and card req/ack handshake between round sequencer and deck.
//  Rev    : 1.0  initial release
// ============================================================================
interface bj_round_ctrl_if;
  logic       shuffle_start;
  logic       shuffle_done;
  logic       card_req;
  logic       card_ack;
  logic [3:0] card_val;

  modport master (
    output shuffle_start, card_req,
    input  shuffle_done, card_ack, card_val
  );

  modport slave (
    input  shuffle_start, card_req,
    output shuffle_done, card_ack, card_val
  );
endinterface
`default_nettype wire

// File: rtl/bj_hand_acc.sv
`default_nettype none
// ============================================================================
//  Module : bj_hand_acc
//  One blackjack hand: raw sum, ace flag, card count, best sum and error.
//  Rev    : 1.0  initial release
// ============================================================================
module bj_hand_acc
  import bj_pkg::*;
(
  input  wire        clk,
  input  wire        rst,
  input  wire        clear,
  input  wire        add,
  input  wire  [3:0] rank,
  output logic [4:0] best,
  output logic [3:0] count,
  output logic       bust,
  output logic       err
);

  logic [4:0] raw;
  logic       has_ace;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw     <= 5'd0;
      has_ace <= 1'b0;
      count   <= 4'd0;
      err     <= 1'b0;
    end else if (clear) begin
      raw     <= 5'd0;
      has_ace <= 1'b0;
      count   <= 4'd0;
      err     <= 1'b0;
    end else if (add) begin
      raw <= raw + card_value(rank);
      if (rank == 4'd1) has_ace <= 1'b1;
      if (bad_rank(rank)) err <= 1'b1;
      if (count != 4'hF) count <= count + 4'd1;
    end
  end

  // A single ace can be promoted to 11 only while it does not overshoot 21.
  assign best = (has_ace && raw <= 5'd11) ? raw + 5'd10 : raw;
  assign bust = best > BJ_LIMIT;

endmodule
`default_nettype wire

// File: rtl/bj_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : bj_round_ctrl
//  Blackjack round sequencer: shuffle, paced deal, player/dealer turns, result.
//  Rev    : 1.0  initial release
// ============================================================================
module bj_round_ctrl
  import bj_pkg::*;
#(
  parameter int                 TIMER_W    = 27,
  parameter logic [TIMER_W-1:0] GAME_TIMER = 27'd50_000_000
) (
  input  wire                    CLOCK_50,
  input  wire                    reset,
  input  wire                    hit_pulse,
  input  wire                    stay_pulse,
  bj_round_ctrl_if.master        deck,
  output logic [4:0]             player_sum,
  output logic [4:0]             dealer_sum,
  output logic [3:0]             player_cards,
  output logic                   dealer_hidden,
  output logic [1:0]             result,
  output logic                   game_over,
  output logic                   card_err
);

  // A zero pacing delay still spends one cycle in WAIT.
  localparam logic [TIMER_W-1:0] LAST_TICK =
    (GAME_TIMER == '0) ? '0 : GAME_TIMER - 1'b1;

  state_t               state;
  state_t               ret_state;
  state_t               next_deal;
  logic [TIMER_W-1:0]   timer;
  logic                 issued;
  logic                 shuffle_pulse;
  logic                 req;
  logic                 take;
  logic                 p_add;
  logic                 d_add;
  logic                 clear_hands;
  logic [4:0]           p_best;
  logic [4:0]           d_best;
  logic [3:0]           d_count;
  logic                 p_bust;
  logic                 d_bust;
  logic                 p_err;
  logic                 d_err;
  logic [4:0]           dealer_first;

  assign take        = req && deck.card_ack;
  assign p_add       = take && (state == DEAL_P1 || state == DEAL_P2 || state == PLAYER_DRAW);
  assign d_add       = take && (state == DEAL_D1 || state == DEAL_D2 || state == DEALER_DRAW);
  assign clear_hands = (state == RESULT) && (hit_pulse || stay_pulse);

  always_comb begin
    next_deal = PLAYER_TURN;
    case (state)
      DEAL_P1:     next_deal = DEAL_D1;
      DEAL_D1:     next_deal = DEAL_P2;
      DEAL_P2:     next_deal = DEAL_D2;
      DEALER_DRAW: next_deal = DEALER_TURN;
      default:     next_deal = PLAYER_TURN;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= SHUFFLE;
      ret_state     <= SHUFFLE;
      timer         <= '0;
      issued        <= 1'b0;
      shuffle_pulse <= 1'b0;
      req           <= 1'b0;
      dealer_hidden <= 1'b1;
      result        <= RES_NONE;
      game_over     <= 1'b0;
    end else begin
      shuffle_pulse <= 1'b0;
      case (state)
        SHUFFLE: begin
          if (!issued) begin
            shuffle_pulse <= 1'b1;
            issued        <= 1'b1;
          end else if (deck.shuffle_done) begin
            state <= DEAL_P1;
          end
        end
        DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_DRAW, DEALER_DRAW: begin
          if (take) begin
            req       <= 1'b0;
            ret_state <= next_deal;
            timer     <= '0;
            state     <= WAIT;
          end else begin
            req <= 1'b1;
          end
        end
        WAIT: begin
          if (timer == LAST_TICK) begin
            timer <= '0;
            state <= ret_state;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PLAYER_TURN: begin
          if (p_bust) begin
            result    <= RES_LOSE;
            game_over <= 1'b1;
            state     <= RESULT;
          end else if (p_best == BJ_LIMIT || stay_pulse) begin
            dealer_hidden <= 1'b0;
            state         <= DEALER_TURN;
          end else if (hit_pulse) begin
            state <= PLAYER_DRAW;
          end
        end
        DEALER_TURN: begin
          if (d_best < DEALER_STAND) begin
            state <= DEALER_DRAW;
          end else begin
            game_over <= 1'b1;
            state     <= RESULT;
            if (d_bust || p_best > d_best) result <= RES_WIN;
            else if (p_best < d_best)      result <= RES_LOSE;
            else                           result <= RES_TIE;
          end
        end
        RESULT: begin
          if (hit_pulse || stay_pulse) begin
            result        <= RES_NONE;
            game_over     <= 1'b0;
            dealer_hidden <= 1'b1;
            issued        <= 1'b0;
            state         <= SHUFFLE;
          end
        end
        default: state <= SHUFFLE;
      endcase
    end
  end

  // Up-card shown on the display while the hole card is concealed.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      dealer_first <= 5'd0;
    end else if (clear_hands) begin
      dealer_first <= 5'd0;
    end else if (d_add && d_count == 4'd0) begin
      dealer_first <= (deck.card_val == 4'd1) ? 5'd11 : card_value(deck.card_val);
    end
  end

  bj_hand_acc u_player (
    .clk   (CLOCK_50),
    .rst   (reset),
    .clear (clear_hands),
    .add   (p_add),
    .rank  (deck.card_val),
    .best  (p_best),
    .count (player_cards),
    .bust  (p_bust),
    .err   (p_err)
  );

  bj_hand_acc u_dealer (
    .clk   (CLOCK_50),
    .rst   (reset),
    .clear (clear_hands),
    .add   (d_add),
    .rank  (deck.card_val),
    .best  (d_best),
    .count (d_count),
    .bust  (d_bust),
    .err   (d_err)
  );

  assign deck.shuffle_start = shuffle_pulse;
  assign deck.card_req      = req;
  assign player_sum         = p_best;
  assign dealer_sum         = dealer_hidden ? dealer_first : d_best;
  assign card_err           = p_err || d_err;

endmodule
`default_nettype wire

// File: tb/tb_bj_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_bj_round_ctrl
//  Directed self-checking bench for the blackjack round sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_bj_round_ctrl;
  import bj_pkg::*;

  localparam int          TW = 27;
  localparam logic [26:0] GT = 27'd10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hit = 1'b0;
  logic       stay = 1'b0;
  logic [4:0] player_sum;
  logic [4:0] dealer_sum;
  logic [3:0] player_cards;
  logic       dealer_hidden;
  logic [1:0] result;
  logic       game_over;
  logic       card_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_ack = -1;

  bj_round_ctrl_if deck();

  bj_round_ctrl #(.TIMER_W(TW), .GAME_TIMER(GT)) dut (
    .CLOCK_50      (clk),
    .reset         (rst),
    .hit_pulse     (hit),
    .stay_pulse    (stay),
    .deck          (deck),
    .player_sum    (player_sum),
    .dealer_sum    (dealer_sum),
    .player_cards  (player_cards),
    .dealer_hidden (dealer_hidden),
    .result        (result),
    .game_over     (game_over),
    .card_err      (card_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!deck.card_req && n < 200) begin
      tick();
      n++;
    end
    check("card_req_seen", 32'(deck.card_req), 32'd1);
  endtask

  task automatic serve(input logic [3:0] v);
    wait_req();
    if (deck.card_req) begin
      if (last_ack >= 0) check("deal_spacing", 32'((cyc - last_ack) >= int'(GT)), 32'd1);
      deck.card_val = v;
      deck.card_ack = 1'b1;
      tick();
      deck.card_ack = 1'b0;
      last_ack = cyc;
      check("card_req_drop", 32'(deck.card_req), 32'd0);
    end
  endtask

  task automatic expect_quiet(input int n);
    int seen = 0;
    repeat (n) begin
      if (deck.card_req) seen++;
      tick();
    end
    check("no_card_req", 32'(seen), 32'd0);
  endtask

  task automatic do_shuffle();
    int n = 0;
    int pulses = 0;
    while (!deck.shuffle_start && n < 10) begin
      tick();
      n++;
    end
    check("shuffle_start", 32'(deck.shuffle_start), 32'd1);
    repeat (4) begin
      if (deck.shuffle_start) pulses++;
      tick();
    end
    check("shuffle_pulse_len", 32'(pulses), 32'd1);
    deck.shuffle_done = 1'b1;
    tick();
    deck.shuffle_done = 1'b0;
    last_ack = -1;
  endtask

  task automatic pulse(input logic h, input logic s);
    hit  = h;
    stay = s;
    tick();
    hit  = 1'b0;
    stay = 1'b0;
  endtask

  task automatic deal4(input logic [3:0] p1, input logic [3:0] d1,
                       input logic [3:0] p2, input logic [3:0] d2);
    serve(p1);
    serve(d1);
    serve(p2);
    serve(d2);
    repeat (15) tick();
  endtask

  task automatic new_round();
    pulse(1'b0, 1'b1);
    check("clr_result", 32'(result), 32'(RES_NONE));
    check("clr_game_over", 32'(game_over), 32'd0);
    check("clr_player_sum", 32'(player_sum), 32'd0);
    check("clr_player_cards", 32'(player_cards), 32'd0);
    check("clr_hidden", 32'(dealer_hidden), 32'd1);
    check("clr_card_err", 32'(card_err), 32'd0);
    do_shuffle();
  endtask

  initial begin
    deck.shuffle_done = 1'b0;
    deck.card_ack     = 1'b0;
    deck.card_val     = 4'd0;
    repeat (3) tick();
    check("rst_card_req", 32'(deck.card_req), 32'd0);
    check("rst_shuffle_start", 32'(deck.shuffle_start), 32'd0);
    check("rst_hidden", 32'(dealer_hidden), 32'd1);
    check("rst_result", 32'(result), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_player_sum", 32'(player_sum), 32'd0);
    rst = 1'b0;
    do_shuffle();

    // Player 10,6 vs dealer 10,7: stay, dealer stands on 17.
    deal4(4'd10, 4'd10, 4'd6, 4'd7);
    check("r1_hidden", 32'(dealer_hidden), 32'd1);
    check("r1_player_sum", 32'(player_sum), 32'd16);
    check("r1_dealer_up", 32'(dealer_sum), 32'd10);
    check("r1_player_cards", 32'(player_cards), 32'd2);
    pulse(1'b0, 1'b1);
    expect_quiet(20);
    check("r1_result", 32'(result), 32'(RES_LOSE));
    check("r1_game_over", 32'(game_over), 32'd1);
    check("r1_dealer_sum", 32'(dealer_sum), 32'd17);
    check("r1_hidden_off", 32'(dealer_hidden), 32'd0);

    // Player 10,5 hits a 9 and busts; dealer never draws.
    new_round();
    deal4(4'd10, 4'd8, 4'd5, 4'd9);
    pulse(1'b1, 1'b0);
    serve(4'd9);
    expect_quiet(25);
    check("r2_player_sum", 32'(player_sum), 32'd24);
    check("r2_result", 32'(result), 32'(RES_LOSE));
    check("r2_player_cards", 32'(player_cards), 32'd3);
    check("r2_hidden", 32'(dealer_hidden), 32'd1);

    // Soft 16 hits a 10 -> hard 16; dealer 9,7 draws 5 -> 21.
    new_round();
    deal4(4'd1, 4'd9, 4'd5, 4'd7);
    check("r3_soft16", 32'(player_sum), 32'd16);
    pulse(1'b1, 1'b0);
    serve(4'd10);
    check("r3_hard16", 32'(player_sum), 32'd16);
    repeat (15) tick();
    pulse(1'b0, 1'b1);
    serve(4'd5);
    expect_quiet(15);
    check("r3_dealer_sum", 32'(dealer_sum), 32'd21);
    check("r3_result", 32'(result), 32'(RES_LOSE));

    // Same start, dealer draws 10 and busts.
    new_round();
    deal4(4'd1, 4'd9, 4'd5, 4'd7);
    pulse(1'b1, 1'b0);
    serve(4'd10);
    repeat (15) tick();
    pulse(1'b0, 1'b1);
    serve(4'd10);
    expect_quiet(15);
    check("r4_dealer_sum", 32'(dealer_sum), 32'd26);
    check("r4_result", 32'(result), 32'(RES_WIN));

    // Hit and stay together: stay wins, 18 vs 18 ties.
    new_round();
    deal4(4'd10, 4'd10, 4'd8, 4'd8);
    pulse(1'b1, 1'b1);
    expect_quiet(20);
    check("r5_player_cards", 32'(player_cards), 32'd2);
    check("r5_result", 32'(result), 32'(RES_TIE));
    check("r5_hidden_off", 32'(dealer_hidden), 32'd0);

    // Reset in the middle of a handshake.
    new_round();
    serve(4'd10);
    serve(4'd10);
    wait_req();
    rst = 1'b1;
    #2;
    check("arst_card_req", 32'(deck.card_req), 32'd0);
    check("arst_player_sum", 32'(player_sum), 32'd0);
    check("arst_dealer_sum", 32'(dealer_sum), 32'd0);
    check("arst_hidden", 32'(dealer_hidden), 32'd1);
    tick();
    rst = 1'b0;
    do_shuffle();

    // Illegal rank 14 counts as 10 and raises card_err.
    deal4(4'd14, 4'd10, 4'd5, 4'd7);
    check("r6_player_sum", 32'(player_sum), 32'd15);
    check("r6_card_err", 32'(card_err), 32'd1);
    pulse(1'b0, 1'b1);
    expect_quiet(20);
    check("r6_result", 32'(result), 32'(RES_LOSE));
    new_round();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bj_round_ctrl.md
Name: bj_round_ctrl

Overview:
Round sequencer for the blackjack game on the DE2-115 top level. It starts a shuffle, paces the initial deal of four cards, and accepts player hit/stay from the debounced key pulses. It then plays the dealer to 17 and publishes hand sums and the round result to the LEDR/HEX display logic. Cards come from the shuffled-deck block over a req/ack handshake; the display drivers read this block's outputs.

Parameters:
GAME_TIMER, 27'd50_000_000, pacing delay in clock cycles after every dealt card; the bench sets 27'd10.
TIMER_W, 27, width of the pacing counter.

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
hit_pulse  in  1  debounced one-cycle pulse, player requests a card
stay_pulse  in  1  debounced one-cycle pulse, player stands
shuffle_start  out  1  one-cycle pulse, starts a deck shuffle
shuffle_done  in  1  level/pulse from the deck block, shuffle complete
card_req  out  1  held high until card_ack
card_ack  in  1  card_val is valid this cycle
card_val  in  4  rank: 1 = ace, 2..10, 11..13 = J/Q/K
player_sum  out  5  player best sum
dealer_sum  out  5  dealer best sum; shows only the first card while dealer_hidden=1
player_cards  out  4  player card count, saturates at 15
dealer_hidden  out  1  dealer hole card concealed
result  out  2  00 none, 01 win, 10 lose, 11 tie
game_over  out  1  high in RESULT state
card_err  out  1  sticky; card_val was 0, 14 or 15 this round

Behaviour:
- Reset values: all outputs 0, except dealer_hidden=1. State is SHUFFLE, timer is 0. The first edge after reset deasserts issues shuffle_start.
- SHUFFLE:
  - Pulse shuffle_start for one cycle.
  - Wait for shuffle_done, then go to DEAL_P1.
- Deal order is DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2.
  - Each deal state raises card_req and holds it until card_ack. On card_ack, card_req drops in the same edge.
  - The card is added to the target hand, then the block enters WAIT for exactly GAME_TIMER cycles before the next state.
  - After DEAL_D2 + WAIT, go to PLAYER_TURN.
- PLAYER_TURN:
  - stay_pulse -> DEALER_TURN. It has priority if hit_pulse arrives in the same cycle.
  - hit_pulse -> PLAYER_DRAW, which is a handshake followed by WAIT.
  - After a player card, player best > 21 -> RESULT with lose; the dealer does not draw.
  - Player best == 21 -> automatic stay.
  - Otherwise return to PLAYER_TURN.
- DEALER_TURN:
  - dealer_hidden is cleared on entry.
  - Dealer best < 17 -> DEALER_DRAW (handshake + WAIT), then re-evaluate.
  - Dealer best >= 17 -> RESULT. Soft 17 stands.
- RESULT:
  - Dealer > 21 -> win. Otherwise player > dealer -> win, less -> lose, equal -> tie.
  - result and game_over hold until a new round.
  - hit_pulse or stay_pulse in RESULT clears both hands, result, card_err and player_cards, sets dealer_hidden, and goes to SHUFFLE.
- Card value: ranks 11..13 count as 10. Ranks 0, 14 and 15 count as 10 and set card_err.
- Hand arithmetic:
  - raw = sum of card values, 5 bits. The maximum reachable raw value is 30, so it never wraps.
  - has_ace is set by any rank 1.
  - best = raw + 10 if has_ace and raw <= 11, else raw.
- Ignore rules:
  - hit/stay pulses in any state other than PLAYER_TURN and RESULT are ignored and not queued.
  - card_ack while card_req=0 is ignored.
  - shuffle_done outside SHUFFLE is ignored.
- Reset mid-handshake or mid-WAIT drops card_req immediately (asynchronously). The deck block treats the deasserted request as aborted.
- The WAIT counter counts 0..GAME_TIMER-1. GAME_TIMER=0 behaves as 1 cycle.

Decomposition:
- Package bj_pkg holds:
  - state enum: SHUFFLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, WAIT, PLAYER_TURN, PLAYER_DRAW, DEALER_TURN, DEALER_DRAW, RESULT;
  - result codes RES_NONE/WIN/LOSE/TIE;
  - constants BJ_LIMIT=21 and DEALER_STAND=17.
- WAIT stores its return state in a register.
- One sub-module, bj_hand_acc, instantiated twice (player and dealer):
  - inputs: clear, add, rank;
  - outputs: best sum, card count, bust flag, err.

Test Plan (all with GAME_TIMER=10):
- Reset pulse then release -> shuffle_start exactly 1 cycle; after shuffle_done, 4 card_req/ack handshakes spaced >= 10 cycles; dealer_hidden=1; PLAYER_TURN reached.
- Player 10,6; dealer 10,7; stay_pulse -> dealer draws no card; result=10 (lose), game_over=1.
- Player 10,5 + hit gives 9 -> player_sum=24, result=lose immediately, no dealer card_req.
- Player A,5 (sum 16 soft); hit gives 10 -> player_sum=16 (ace now hard); dealer 9,7 + draw 5 -> dealer_sum=21, lose. Dealer 9,7 + draw 10 -> bust, win.
- hit_pulse and stay_pulse in the same cycle in PLAYER_TURN -> no card_req, DEALER_TURN entered.
- Reset asserted while card_req=1 -> card_req=0 asynchronously, all outputs at reset values; card_val=14 in a later round -> card_err=1, counted as 10.
